// File: rtl/ddr2_refresh_scheduler.sv
// DDR2 AUTO REFRESH scheduler: tREFI credit timer, arbiter handshake, REF issue and tRFC hold-off.
// Optional statistics outputs (ref_count_o, max_pending_o) are built when DDR2_REFSCHED_STATS_EN is defined.
//
//  state     | meaning
//  ----------+---------------------------------------------------------------
//  IDLE      | waiting; requests the bus whenever refresh credits are owed
//  ISSUE     | single cycle with AUTO REFRESH on the command pins
//  TRFC_WAIT | remainder of tRFC; bus held busy, no new request
module ddr2_refresh_scheduler #(
    parameter int TREFI_CLK    = 100000,
    parameter int TRFC_CLK     = 26,
    parameter int MAX_POSTPONE = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ready_i,
    input  logic        ref_gnt_i,
    output logic        ref_req_o,
    output logic        urgent_o,
    output logic        ref_busy_o,
    output logic [3:0]  pending_o,
    output logic        overflow_o,
`ifdef DDR2_REFSCHED_STATS_EN
    output logic [31:0] ref_count_o,
    output logic [3:0]  max_pending_o,
`endif
    output logic        ref_csbar_o,
    output logic        ref_rasbar_o,
    output logic        ref_casbar_o,
    output logic        ref_webar_o
);

    localparam int CW        = (TREFI_CLK > 2) ? $clog2(TREFI_CLK) : 1;
    localparam int TW        = (TRFC_CLK > 2) ? $clog2(TRFC_CLK) : 1;
    localparam int TRFC_LOAD = (TRFC_CLK >= 2) ? (TRFC_CLK - 2) : 0;

    localparam logic [CW-1:0] TREFI_LAST   = CW'(TREFI_CLK - 1);
    localparam logic [TW-1:0] TRFC_INIT    = TW'(TRFC_LOAD);
    localparam logic [3:0]    PENDING_MAX  = 4'(MAX_POSTPONE + 1);
    localparam logic [3:0]    URGENT_LEVEL = 4'(MAX_POSTPONE);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        TRFC_WAIT = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   interval_cnt;
    logic [TW-1:0]   trfc_cnt;

    logic            tick;
    logic            consume;
    logic            issue_start;
    logic            overflow_set;
    logic [3:0]      pending_nxt;

    always_comb begin
        tick         = ready_i && (interval_cnt == TREFI_LAST);
        consume      = (state == ISSUE);
        issue_start  = ready_i && (state == IDLE) && ref_req_o && ref_gnt_i;
        pending_nxt  = pending_o;
        overflow_set = 1'b0;
        // A tick and a consume in the same cycle cancel out.
        if (tick && !consume) begin
            if (pending_o == PENDING_MAX) begin
                overflow_set = 1'b1;
            end else begin
                pending_nxt = pending_o + 4'd1;
            end
        end else if (!tick && consume) begin
            pending_nxt = pending_o - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            interval_cnt <= '0;
            trfc_cnt     <= '0;
            pending_o    <= 4'd0;
            urgent_o     <= 1'b0;
            ref_req_o    <= 1'b0;
            ref_busy_o   <= 1'b0;
            overflow_o   <= 1'b0;
            ref_csbar_o  <= 1'b1;
            ref_rasbar_o <= 1'b1;
            ref_casbar_o <= 1'b1;
            ref_webar_o  <= 1'b1;
        end else if (!ready_i) begin
            state        <= IDLE;
            interval_cnt <= '0;
            trfc_cnt     <= '0;
            pending_o    <= 4'd0;
            urgent_o     <= 1'b0;
            ref_req_o    <= 1'b0;
            ref_busy_o   <= 1'b0;
            ref_csbar_o  <= 1'b1;
            ref_rasbar_o <= 1'b1;
            ref_casbar_o <= 1'b1;
            ref_webar_o  <= 1'b1;
        end else begin
            interval_cnt <= tick ? '0 : interval_cnt + 1'b1;
            pending_o    <= pending_nxt;
            urgent_o     <= (pending_nxt >= URGENT_LEVEL);
            if (overflow_set) begin
                overflow_o <= 1'b1;
            end

            ref_csbar_o  <= 1'b1;
            ref_rasbar_o <= 1'b1;
            ref_casbar_o <= 1'b1;
            ref_webar_o  <= 1'b1;
            ref_busy_o   <= 1'b0;
            ref_req_o    <= 1'b0;

            case (state)
                IDLE: begin
                    if (issue_start) begin
                        state        <= ISSUE;
                        ref_csbar_o  <= 1'b0;
                        ref_rasbar_o <= 1'b0;
                        ref_casbar_o <= 1'b0;
                        ref_busy_o   <= 1'b1;
                    end else begin
                        ref_req_o <= (pending_nxt != 4'd0);
                    end
                end
                ISSUE: begin
                    if (TRFC_CLK == 1) begin
                        state     <= IDLE;
                        ref_req_o <= (pending_nxt != 4'd0);
                    end else begin
                        state      <= TRFC_WAIT;
                        trfc_cnt   <= TRFC_INIT;
                        ref_busy_o <= 1'b1;
                    end
                end
                TRFC_WAIT: begin
                    if (trfc_cnt == '0) begin
                        state     <= IDLE;
                        ref_req_o <= (pending_nxt != 4'd0);
                    end else begin
                        trfc_cnt   <= trfc_cnt - 1'b1;
                        ref_busy_o <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DDR2_REFSCHED_STATS_EN
    // Statistics survive ready_i drops; only the hard reset clears them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ref_count_o   <= 32'd0;
            max_pending_o <= 4'd0;
        end else begin
            if (issue_start && (ref_count_o != 32'hFFFF_FFFF)) begin
                ref_count_o <= ref_count_o + 32'd1;
            end
            if (pending_o > max_pending_o) begin
                max_pending_o <= pending_o;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ddr2_refresh_scheduler.sv
// Directed bench for ddr2_refresh_scheduler with TREFI_CLK=100, TRFC_CLK=4, MAX_POSTPONE=8.
// Cycle numbers are counted from the cycle in which ready_i is raised (cycle 0).
module tb_ddr2_refresh_scheduler;

    logic        clk;
    logic        reset;
    logic        ready_i;
    logic        ref_gnt_i;
    logic        ref_req_o;
    logic        urgent_o;
    logic        ref_busy_o;
    logic [3:0]  pending_o;
    logic        overflow_o;
    logic        ref_csbar_o;
    logic        ref_rasbar_o;
    logic        ref_casbar_o;
    logic        ref_webar_o;
`ifdef DDR2_REFSCHED_STATS_EN
    logic [31:0] ref_count_o;
    logic [3:0]  max_pending_o;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    ddr2_refresh_scheduler #(
        .TREFI_CLK    (100),
        .TRFC_CLK     (4),
        .MAX_POSTPONE (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ready_i      (ready_i),
        .ref_gnt_i    (ref_gnt_i),
        .ref_req_o    (ref_req_o),
        .urgent_o     (urgent_o),
        .ref_busy_o   (ref_busy_o),
        .pending_o    (pending_o),
        .overflow_o   (overflow_o),
`ifdef DDR2_REFSCHED_STATS_EN
        .ref_count_o  (ref_count_o),
        .max_pending_o(max_pending_o),
`endif
        .ref_csbar_o  (ref_csbar_o),
        .ref_rasbar_o (ref_rasbar_o),
        .ref_casbar_o (ref_casbar_o),
        .ref_webar_o  (ref_webar_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    // One cycle with ready_i low, then ready_i high: the following cycle is cycle 0.
    task automatic start();
        ready_i = 1'b0;
        step();
        ready_i = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0; ready_i = 1'b0; ref_gnt_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ref_csbar_o, ref_rasbar_o, ref_casbar_o, ref_webar_o} !== 4'b1111) begin
            errors++; $display("FAIL reset_pins got %b want 1111",
                {ref_csbar_o, ref_rasbar_o, ref_casbar_o, ref_webar_o});
        end
        checks++;
        if ({ref_req_o, urgent_o, ref_busy_o, overflow_o, pending_o} !== 8'h00) begin
            errors++; $display("FAIL reset_status got req=%b urg=%b busy=%b ovf=%b pend=%0d want all 0",
                ref_req_o, urgent_o, ref_busy_o, overflow_o, pending_o);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_periodic();
        int first_ref = -1, second_ref = -1, nref = 0, nbusy = 0;
        start();
        ref_gnt_i = 1'b1;
        while (cyc < 210) begin
            step();
            if (cyc == 99) begin
                checks++;
                if (ref_req_o !== 1'b0) begin errors++; $display("FAIL req_before_tick got %b want 0", ref_req_o); end
            end
            if (cyc == 100) begin
                checks++;
                if (ref_req_o !== 1'b1) begin errors++; $display("FAIL req_first got %b want 1", ref_req_o); end
            end
            if (ref_csbar_o === 1'b0) begin
                nref++;
                if (first_ref < 0) first_ref = cyc;
                else if (second_ref < 0) second_ref = cyc;
                checks++;
                if ({ref_rasbar_o, ref_casbar_o, ref_webar_o} !== 3'b001) begin
                    errors++; $display("FAIL ref_encoding at %0d got %b want 001", cyc,
                        {ref_rasbar_o, ref_casbar_o, ref_webar_o});
                end
            end
            if (cyc >= 100 && cyc <= 110 && ref_busy_o === 1'b1) nbusy++;
            if (cyc == 104 || cyc == 105) begin
                checks++;
                if (ref_busy_o !== (cyc == 104)) begin
                    errors++; $display("FAIL busy_edge at %0d got %b want %b", cyc, ref_busy_o, cyc == 104);
                end
            end
        end
        checks++;
        if (first_ref != 101) begin errors++; $display("FAIL first_ref_cycle got %0d want 101", first_ref); end
        checks++;
        if (second_ref != 201) begin errors++; $display("FAIL second_ref_cycle got %0d want 201", second_ref); end
        checks++;
        if (nref != 2) begin errors++; $display("FAIL periodic_ref_count got %0d want 2", nref); end
        checks++;
        if (nbusy != 4) begin errors++; $display("FAIL busy_length got %0d want 4", nbusy); end
    endtask

    task automatic test_postpone();
        int nref = 0, last_ref = -1, first_ref = -1;
        start();
        ref_gnt_i = 1'b0;
        step_to(700);
        checks++;
        if (pending_o !== 4'd7 || urgent_o !== 1'b0) begin
            errors++; $display("FAIL postpone_7 got pend=%0d urg=%b want 7/0", pending_o, urgent_o);
        end
        step_to(800);
        checks++;
        if (pending_o !== 4'd8 || urgent_o !== 1'b1 || ref_req_o !== 1'b1) begin
            errors++; $display("FAIL postpone_8 got pend=%0d urg=%b req=%b want 8/1/1", pending_o, urgent_o, ref_req_o);
        end
        ref_gnt_i = 1'b1;
        while (cyc < 880) begin
            step();
            if (ref_csbar_o === 1'b0) begin
                nref++;
                if (first_ref < 0) first_ref = cyc;
                if (last_ref >= 0) begin
                    checks++;
                    if (cyc - last_ref != 5) begin
                        errors++; $display("FAIL drain_spacing at %0d got %0d want 5", cyc, cyc - last_ref);
                    end
                end
                last_ref = cyc;
            end
        end
        checks++;
        if (nref != 8 || first_ref != 801) begin
            errors++; $display("FAIL drain_count got n=%0d first=%0d want 8/801", nref, first_ref);
        end
        checks++;
        if (pending_o !== 4'd0 || urgent_o !== 1'b0 || overflow_o !== 1'b0 || ref_req_o !== 1'b0) begin
            errors++; $display("FAIL drain_end got pend=%0d urg=%b ovf=%b req=%b want 0/0/0/0",
                pending_o, urgent_o, overflow_o, ref_req_o);
        end
    endtask

    task automatic test_overflow();
        int nref = 0;
        start();
        ref_gnt_i = 1'b0;
        step_to(999);
        checks++;
        if (pending_o !== 4'd9 || overflow_o !== 1'b0) begin
            errors++; $display("FAIL ovf_before got pend=%0d ovf=%b want 9/0", pending_o, overflow_o);
        end
        step();
        checks++;
        if (pending_o !== 4'd9 || overflow_o !== 1'b1 || urgent_o !== 1'b1) begin
            errors++; $display("FAIL ovf_set got pend=%0d ovf=%b urg=%b want 9/1/1", pending_o, overflow_o, urgent_o);
        end
        ref_gnt_i = 1'b1;
        while (cyc < 1050) begin
            step();
            if (ref_csbar_o === 1'b0) nref++;
        end
        ref_gnt_i = 1'b0;
        checks++;
        if (nref != 9 || pending_o !== 4'd0 || overflow_o !== 1'b1) begin
            errors++; $display("FAIL ovf_drain got n=%0d pend=%0d ovf=%b want 9/0/1", nref, pending_o, overflow_o);
        end
    endtask

    task automatic test_coincide();
        start();
        ref_gnt_i = 1'b0;
        step_to(100);
        checks++;
        if (overflow_o !== 1'b1 || pending_o !== 4'd1) begin
            errors++; $display("FAIL ovf_retained got ovf=%b pend=%0d want 1/1", overflow_o, pending_o);
        end
        step_to(198);
        ref_gnt_i = 1'b1;
        step();
        ref_gnt_i = 1'b0;
        checks++;
        if (ref_csbar_o !== 1'b0 || pending_o !== 4'd1) begin
            errors++; $display("FAIL coincide_issue got cs=%b pend=%0d want 0/1", ref_csbar_o, pending_o);
        end
        step();
        checks++;
        if (pending_o !== 4'd1) begin errors++; $display("FAIL coincide_pending got %0d want 1", pending_o); end
        step_to(202);
        checks++;
        if (ref_req_o !== 1'b0 || ref_busy_o !== 1'b1) begin
            errors++; $display("FAIL coincide_trfc got req=%b busy=%b want 0/1", ref_req_o, ref_busy_o);
        end
        step();
        checks++;
        if (ref_req_o !== 1'b1 || ref_busy_o !== 1'b0) begin
            errors++; $display("FAIL coincide_rereq got req=%b busy=%b want 1/0", ref_req_o, ref_busy_o);
        end
        ref_gnt_i = 1'b1;
        step();
        ref_gnt_i = 1'b0;
        checks++;
        if (ref_csbar_o !== 1'b0) begin errors++; $display("FAIL coincide_second_ref got cs=%b want 0", ref_csbar_o); end
    endtask

    task automatic test_ready_drop();
        start();
        ref_gnt_i = 1'b0;
        step_to(200);
        ref_gnt_i = 1'b1;
        step();
        ref_gnt_i = 1'b0;
        checks++;
        if (ref_csbar_o !== 1'b0) begin errors++; $display("FAIL drop_ref at 201 got cs=%b want 0", ref_csbar_o); end
        step();
        checks++;
        if (ref_busy_o !== 1'b1 || pending_o !== 4'd1) begin
            errors++; $display("FAIL drop_pre got busy=%b pend=%0d want 1/1", ref_busy_o, pending_o);
        end
        ready_i = 1'b0;
        step();
        checks++;
        if (ref_busy_o !== 1'b0 || pending_o !== 4'd0 || ref_req_o !== 1'b0 ||
            {ref_csbar_o, ref_rasbar_o, ref_casbar_o, ref_webar_o} !== 4'b1111) begin
            errors++; $display("FAIL drop_clear got busy=%b pend=%0d req=%b pins=%b want 0/0/0/1111",
                ref_busy_o, pending_o, ref_req_o, {ref_csbar_o, ref_rasbar_o, ref_casbar_o, ref_webar_o});
        end
    endtask

    task automatic test_reset_mid_issue();
        start();
        ref_gnt_i = 1'b1;
        step_to(99);
        checks++;
        if (ref_req_o !== 1'b0) begin errors++; $display("FAIL rerise_early got req=%b want 0", ref_req_o); end
        step();
        checks++;
        if (ref_req_o !== 1'b1) begin errors++; $display("FAIL rerise_tick got req=%b want 1", ref_req_o); end
        step();
        checks++;
        if (ref_csbar_o !== 1'b0 || overflow_o !== 1'b1) begin
            errors++; $display("FAIL mid_issue got cs=%b ovf=%b want 0/1", ref_csbar_o, overflow_o);
        end
`ifdef DDR2_REFSCHED_STATS_EN
        checks++;
        if (ref_count_o !== 32'd23 || max_pending_o !== 4'd9) begin
            errors++; $display("FAIL stats_before got cnt=%0d max=%0d want 23/9", ref_count_o, max_pending_o);
        end
`endif
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if ({ref_csbar_o, ref_rasbar_o, ref_casbar_o, ref_webar_o} !== 4'b1111 ||
            overflow_o !== 1'b0 || ref_busy_o !== 1'b0 || pending_o !== 4'd0) begin
            errors++; $display("FAIL async_reset got pins=%b ovf=%b busy=%b pend=%0d want 1111/0/0/0",
                {ref_csbar_o, ref_rasbar_o, ref_casbar_o, ref_webar_o}, overflow_o, ref_busy_o, pending_o);
        end
`ifdef DDR2_REFSCHED_STATS_EN
        checks++;
        if (ref_count_o !== 32'd0 || max_pending_o !== 4'd0) begin
            errors++; $display("FAIL stats_after got cnt=%0d max=%0d want 0/0", ref_count_o, max_pending_o);
        end
`endif
        ref_gnt_i = 1'b0;
        ready_i = 1'b0;
        step();
        reset = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_postpone();
        test_overflow();
        test_coincide();
        test_ready_drop();
        test_reset_mid_issue();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
